x2_bist_harness: RTL

- Built-in self-test wrapper that sits directly around the x2 combinational benchmark core.
- Upstream stage: a 10-bit LFSR pattern generator drives the core's pi0..pi9 inputs.
- Downstream stage: a 7-bit MISR compacts the core's po0..po6 responses into a signature.
- Purpose: exercise the benchmark (and its reversible/synthesised variants) on silicon or in simulation, with one start/done handshake and a single compared signature.

---
 rtl/x2_bist_harness.sv | 103 ++++++++++
 1 files changed

// File: rtl/x2_bist_harness.sv
// BIST wrapper for the x2 combinational core. A 10-bit LFSR drives the core
// inputs, and a 7-bit MISR compacts its responses into one signature.
module x2_bist_harness #(
   parameter int                N_PI      = 10,
   parameter int                N_PO      = 7,
   parameter int                CNT_W     = 16,
   parameter logic [N_PI-1:0]   LFSR_SEED = 10'h001
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] pattern_count,
   output logic [N_PI-1:0]  pi_vec,
   output logic             pi_valid,
   input  logic [N_PO-1:0]  po_vec,
   output logic             busy,
   output logic             done,
   output logic [N_PO-1:0]  signature
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_next_state;
   logic [N_PI-1:0]  r_lfsr;
   logic [N_PO-1:0]  r_misr;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_len;

   logic             w_accept;
   logic             w_last;
   logic [N_PI-1:0]  w_lfsr_next;
   logic [N_PO-1:0]  w_misr_next;

   // Fibonacci LFSR x^10+x^7+1 and MISR x^7+x^6+1.
   assign w_lfsr_next = {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
   assign w_misr_next = {r_misr[5:0], r_misr[6] ^ r_misr[5]} ^ po_vec;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_next_state = (pattern_count != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            w_last = (r_cnt == r_len - CNT_ONE);
            if (w_last) begin
               w_next_state = S_DONE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments and an asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lfsr <= LFSR_SEED;
         r_misr <= '0;
         r_cnt  <= '0;
         r_len  <= '0;
      end else if (w_accept) begin
         r_lfsr <= LFSR_SEED;
         r_misr <= '0;
         r_cnt  <= '0;
         r_len  <= pattern_count;
      end else if (r_state == S_RUN) begin
         r_misr <= w_misr_next;
         r_cnt  <= r_cnt + CNT_ONE;
         // The final pattern stays on pi_vec so DONE shows what was last applied.
         if (!w_last) begin
            r_lfsr <= w_lfsr_next;
         end
      end
   end

   assign pi_vec    = r_lfsr;
   assign signature = r_misr;
   assign pi_valid  = (r_state == S_RUN);
   assign busy      = (r_state == S_RUN);
   assign done      = (r_state == S_DONE);

endmodule
